// File: rtl/axis_fifo_param.sv
// Parametrised first-word-fall-through stream FIFO with flush, occupancy level,
// almost-full/almost-empty flags and a high-water-mark register.
module axis_fifo_param #(
    parameter int WIDTH     = 45,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                       axis_clk,
    input  logic                       axi_reset_n,
    input  logic                       flush,
    input  logic                       w_vld,
    output logic                       w_rdy,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_rdy,
    output logic                       r_vld,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     hwm
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds are widened by one bit so AF_THRESH == DEPTH still compares correctly.
    localparam logic [AW+1:0] AF_LIMIT = (AW+2)'(AF_THRESH);
    localparam logic [AW+1:0] AE_LIMIT = (AW+2)'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] w_ptr;
    logic [AW:0] r_ptr;
    logic [AW:0] level_next;
    logic [AW:0] hwm_q;
    logic        rdy_en;
    logic        full;
    logic        empty;
    logic        wr_en;
    logic        rd_en;

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[AW-1:0] == r_ptr[AW-1:0]) && (w_ptr[AW] != r_ptr[AW]);

    assign w_rdy = rdy_en & ~full & ~flush;
    assign r_vld = ~empty & ~flush;

    assign wr_en = w_vld & w_rdy;
    assign rd_en = r_vld & r_rdy;

    assign level    = w_ptr - r_ptr;
    assign data_out = mem[r_ptr[AW-1:0]];

    assign almost_full  = ({1'b0, level} >= AF_LIMIT);
    assign almost_empty = ({1'b0, level} <= AE_LIMIT);

    assign hwm = hwm_q;

    always_comb begin
        level_next = level;
        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            w_ptr  <= '0;
            r_ptr  <= '0;
            hwm_q  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
                hwm_q <= '0;
            end else begin
                if (wr_en) begin
                    w_ptr <= w_ptr + 1'b1;
                end
                if (rd_en) begin
                    r_ptr <= r_ptr + 1'b1;
                end
                if (level_next > hwm_q) begin
                    hwm_q <= level_next;
                end
            end
        end
    end

    // Storage is deliberately not reset; stale words are hidden behind r_vld.
    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem[w_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_axis_fifo_param.sv
// Randomised and directed bench for axis_fifo_param, checked every cycle against
// a queue-based model plus literal expectations for the directed scenarios.
module tb_axis_fifo_param;

    localparam int WIDTH = 45;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
    localparam int AW    = $clog2(DEPTH);

    logic             axis_clk;
    logic             axi_reset_n;
    logic             flush;
    logic             w_vld;
    logic             w_rdy;
    logic [WIDTH-1:0] data_in;
    logic             r_rdy;
    logic             r_vld;
    logic [WIDTH-1:0] data_out;
    logic [AW:0]      level;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      hwm;

    int pass_count  = 0;
    int check_count = 0;

    // Behavioural model: a queue of stored words, the high-water mark and the ready enable.
    logic [WIDTH-1:0] model_q [$];
    int               model_hwm = 0;
    bit               model_en  = 0;
    bit               compare_on = 0;

    axis_fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .axis_clk(axis_clk),
        .axi_reset_n(axi_reset_n),
        .flush(flush),
        .w_vld(w_vld),
        .w_rdy(w_rdy),
        .data_in(data_in),
        .r_rdy(r_rdy),
        .r_vld(r_vld),
        .data_out(data_out),
        .level(level),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .hwm(hwm)
    );

    initial begin
        axis_clk = 1'b0;
        forever #5 axis_clk = ~axis_clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic applyStimulus(input bit wv, input logic [WIDTH-1:0] d, input bit rr, input bit fl);
        @(posedge axis_clk);
        #1;
        w_vld   = wv;
        data_in = d;
        r_rdy   = rr;
        flush   = fl;
    endtask

    function automatic bit expWrdy();
        return model_en && (model_q.size() < DEPTH) && !flush;
    endfunction

    function automatic bit expRvld();
        return (model_q.size() > 0) && !flush;
    endfunction

    always @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            model_q.delete();
            model_hwm = 0;
            model_en  = 0;
        end else begin
            bit do_wr;
            bit do_rd;
            do_wr = w_vld && expWrdy();
            do_rd = r_rdy && expRvld();
            if (flush) begin
                model_q.delete();
                model_hwm = 0;
            end else begin
                if (do_rd) void'(model_q.pop_front());
                if (do_wr) model_q.push_back(data_in);
                if (model_q.size() > model_hwm) model_hwm = model_q.size();
            end
            model_en = 1;
        end
    end

    always @(negedge axis_clk) begin
        if (compare_on) begin
            checkOutput("w_rdy", 64'(w_rdy), 64'(expWrdy()));
            checkOutput("r_vld", 64'(r_vld), 64'(expRvld()));
            checkOutput("level", 64'(level), 64'(model_q.size()));
            checkOutput("almost_full", 64'(almost_full), 64'(model_q.size() >= AF));
            checkOutput("almost_empty", 64'(almost_empty), 64'(model_q.size() <= AE));
            checkOutput("hwm", 64'(hwm), 64'(model_hwm));
            if (expRvld() && model_q.size() > 0) begin
                checkOutput("data_out", 64'(data_out), 64'(model_q[0]));
            end
        end
    end

    initial begin
        axi_reset_n = 1'b0;
        flush       = 1'b0;
        w_vld       = 1'b1;
        data_in     = 45'h1;
        r_rdy       = 1'b0;
        compare_on  = 1'b1;

        // Reset values and first write after release
        @(negedge axis_clk);
        checkOutput("rst_w_rdy", 64'(w_rdy), 64'd0);
        checkOutput("rst_level", 64'(level), 64'd0);
        checkOutput("rst_almost_empty", 64'(almost_empty), 64'd1);
        @(posedge axis_clk);
        #2 axi_reset_n = 1'b1;
        @(negedge axis_clk);
        checkOutput("release_w_rdy_low", 64'(w_rdy), 64'd0);
        @(negedge axis_clk);
        checkOutput("release_w_rdy_high", 64'(w_rdy), 64'd1);
        checkOutput("release_r_vld_low", 64'(r_vld), 64'd0);
        applyStimulus(0, '0, 0, 0);
        @(negedge axis_clk);
        checkOutput("first_r_vld", 64'(r_vld), 64'd1);
        checkOutput("first_data", 64'(data_out), 64'h1);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        // Fill to full with no reads
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 45'(32'h10 + i), 0, 0);
            @(negedge axis_clk);
            checkOutput("fill_level", 64'(level), 64'(i));
            checkOutput("fill_ae", 64'(almost_empty), 64'(i <= 1));
            checkOutput("fill_af", 64'(almost_full), 64'(i >= 6));
        end
        applyStimulus(1, 45'h99, 0, 0);
        @(negedge axis_clk);
        checkOutput("full_level", 64'(level), 64'd8);
        checkOutput("full_w_rdy", 64'(w_rdy), 64'd0);
        checkOutput("full_hwm", 64'(hwm), 64'd8);
        applyStimulus(1, 45'h98, 0, 0);
        @(negedge axis_clk);
        checkOutput("refused_level", 64'(level), 64'd8);

        // Drain in order
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, '0, 1, 0);
            @(negedge axis_clk);
            checkOutput("drain_data", 64'(data_out), 64'(32'h10 + i));
        end
        applyStimulus(0, '0, 0, 0);
        @(negedge axis_clk);
        checkOutput("drained_r_vld", 64'(r_vld), 64'd0);
        checkOutput("drained_level", 64'(level), 64'd0);
        checkOutput("drained_hwm", 64'(hwm), 64'd8);

        // Flush to clear the high-water mark, then stream 20 words
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 0);
        @(negedge axis_clk);
        checkOutput("flush_hwm", 64'(hwm), 64'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 45'(32'h100 + i), 1, 0);
            @(negedge axis_clk);
            if (i > 0) begin
                checkOutput("stream_level", 64'(level), 64'd1);
                checkOutput("stream_data", 64'(data_out), 64'(32'h100 + i - 1));
            end
        end
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);
        @(negedge axis_clk);
        checkOutput("stream_hwm", 64'(hwm), 64'd1);
        checkOutput("stream_end_level", 64'(level), 64'd0);

        // Flush while both sides are requesting
        for (int i = 0; i < 5; i++) applyStimulus(1, 45'(32'h200 + i), 0, 0);
        applyStimulus(1, 45'h55, 1, 1);
        @(negedge axis_clk);
        checkOutput("flush_level_before", 64'(level), 64'd5);
        checkOutput("flush_w_rdy", 64'(w_rdy), 64'd0);
        checkOutput("flush_r_vld", 64'(r_vld), 64'd0);
        applyStimulus(1, 45'hAA, 1, 0);
        @(negedge axis_clk);
        checkOutput("after_flush_level", 64'(level), 64'd0);
        checkOutput("after_flush_hwm", 64'(hwm), 64'd0);
        applyStimulus(0, '0, 1, 0);
        @(negedge axis_clk);
        checkOutput("after_flush_data", 64'(data_out), 64'hAA);
        applyStimulus(0, '0, 0, 0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) applyStimulus(1, 45'(32'h300 + i), 0, 0);
        applyStimulus(0, '0, 0, 0);
        #2 axi_reset_n = 1'b0;
        #1;
        checkOutput("async_level", 64'(level), 64'd0);
        checkOutput("async_r_vld", 64'(r_vld), 64'd0);
        checkOutput("async_w_rdy", 64'(w_rdy), 64'd0);
        checkOutput("async_hwm", 64'(hwm), 64'd0);
        @(posedge axis_clk);
        #2 axi_reset_n = 1'b1;

        // Randomised traffic with occasional flush
        for (int i = 0; i < 800; i++) begin
            logic [63:0] rnd;
            rnd = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 9) < 7), rnd[WIDTH-1:0],
                          ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) < 3));
        end
        applyStimulus(0, '0, 0, 0);
        @(negedge axis_clk);
        compare_on = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/axis_fifo_param.md
Name: axis_fifo_param

Overview:
Parametrised successor of the team's AXI-Stream-style FIFO. It stores WIDTH-bit words in a flop-based circular buffer of DEPTH entries and uses the same w_vld/w_rdy and r_vld/r_rdy handshake. It adds four features over the current block:
- synchronous flush
- occupancy level output
- programmable almost-full/almost-empty flags
- high-water-mark register
It sits between stream producers and consumers wherever buffering depth must be tuned per instance.

Parameters:
- WIDTH, 45, data word width in bits (1..128).
- DEPTH, 64, number of entries; power of two, >= 4.
- AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1).
- AW (localparam), log2(DEPTH), pointer index width.

Ports:
- axis_clk  in  1  clock, all logic on rising edge.
- axi_reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush, level-sensitive, highest priority after reset.
- w_vld  in  1  write data valid.
- w_rdy  out  1  FIFO can accept a word.
- data_in  in  WIDTH  write data.
- r_rdy  in  1  consumer accepts a word.
- r_vld  out  1  data_out holds a valid word.
- data_out  out  WIDTH  head-of-FIFO word (first-word-fall-through).
- level  out  AW+1  current occupancy, 0..DEPTH.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- hwm  out  AW+1  maximum occupancy reached since reset or last flush.

Behaviour:
Reset:
- Asynchronous, active-low. Sets w_ptr=0, r_ptr=0, hwm=0, and the ready-enable flop rdy_en=0.
- Storage array is not reset.
- Output values during reset: w_rdy=0, r_vld=0, level=0, almost_full=(AF_THRESH==0 ? 1 : 0), almost_empty=1, hwm=0.
- rdy_en sets at the first rising edge after release. w_rdy can therefore first be 1 in the cycle after that edge.

Pointers and status:
- w_ptr and r_ptr are AW+1 bits wide; the MSB is the wrap bit.
- empty when the pointers are equal. Full when the low AW bits are equal and the MSBs differ.
- level = w_ptr - r_ptr, modulo 2^(AW+1).

Handshake:
- w_rdy = rdy_en & !full & !flush.
- r_vld = !empty & !flush.
- Write accepted when w_vld & w_rdy: mem[w_ptr[AW-1:0]] <= data_in and w_ptr increments at the edge.
- Read accepted when r_vld & r_rdy: r_ptr increments at the edge.
- data_out = mem[r_ptr[AW-1:0]], combinational from registered state. It is don't-care when r_vld=0.
- No combinational path from w_vld/r_rdy to w_rdy/r_vld.

Latency:
- A word written into an empty FIFO appears on data_out with r_vld=1 in the next cycle. There is no same-cycle bypass.
- A read from a full FIFO raises w_rdy in the next cycle.

Simultaneous events:
- Read and write in the same cycle leave level unchanged. This holds at any non-empty, non-full level.
- When full, w_rdy=0, so only a read is accepted in that cycle.
- When empty, r_vld=0, so only a write is accepted.

Wrap-around:
- Pointers roll over naturally; the storage index wraps DEPTH-1 -> 0.
- level must stay correct across wraps.

Flags:
- almost_full and almost_empty are combinational decodes of the registered level.

High-water mark:
- hwm <= max(hwm, level_next) at every edge, where level_next is the post-update occupancy.
- Therefore hwm >= level always holds.

Flush:
- While flush=1, w_rdy=0 and r_vld=0, so no transfer occurs.
- At the edge: w_ptr=r_ptr=0 and hwm=0.
- Storage contents are stale and never exposed.
- Normal operation resumes the cycle after flush deasserts.

Reset mid-operation:
- Immediately forces the reset values listed above.
- All buffered data is lost.

Test Plan:
Bench configuration for all scenarios: WIDTH=45, DEPTH=8, AF_THRESH=6, AE_THRESH=1.
- Reset release, w_vld=1 held with data 0x1 -> w_rdy is 0 until the first edge after release. The write is accepted next cycle, and r_vld=1 with data_out=0x1 one cycle after that.
- Write 8 words 0x10..0x17 with r_rdy=0 ->
  - level steps 1..8; almost_empty drops when level=2; almost_full rises when level=6.
  - w_rdy=0 at level 8; a 9th w_vld is refused with level staying 8; hwm=8.
- From full, assert r_rdy=1 for 8 cycles -> data_out reads 0x10..0x17 in order; r_vld=0 after the 8th read; level=0; hwm stays 8.
- Continuous w_vld=1, r_rdy=1 streaming of 20 words (pointer wrap twice) -> output order is preserved, level stays at 1 after the first word, and hwm=1.
- Fill to level 5, then pulse flush=1 for one cycle while w_vld=r_rdy=1 -> no transfer in the flush cycle, level=0 and hwm=0 after it, and the next write 0xAA is read back first.
- Fill to level 4, then assert axi_reset_n=0 asynchronously mid-cycle -> level=0, r_vld=0, w_rdy=0 immediately, with no clock edge needed.
